// File: rtl/c_ins_loader_if.sv
// Byte-stream and instruction-write bundle between the program-mode host and c_ins_loader.
// The slave modport is the loader's view; the master modport is the host/bench view.
interface c_ins_loader_if #(
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);

  logic          i_c_load_start;
  logic          i_c_load_end;
  logic [7:0]    i_c_byte;
  logic          i_c_byte_valid;
  logic          o_c_byte_ready;
  logic [31:0]   o_c_write_ins;
  logic          o_c_ins_wr;
  logic [AW-1:0] o_c_ins_addr;
  logic [AW:0]   o_c_word_count;
  logic          o_c_cpu_reset;
  logic          o_c_load_done;

  modport slave (
    input  i_c_load_start, i_c_load_end, i_c_byte, i_c_byte_valid,
    output o_c_byte_ready, o_c_write_ins, o_c_ins_wr, o_c_ins_addr,
           o_c_word_count, o_c_cpu_reset, o_c_load_done
  );

  modport master (
    output i_c_load_start, i_c_load_end, i_c_byte, i_c_byte_valid,
    input  o_c_byte_ready, o_c_write_ins, o_c_ins_wr, o_c_ins_addr,
           o_c_word_count, o_c_cpu_reset, o_c_load_done
  );
endinterface

// File: rtl/c_ins_loader.sv
// Program-mode loader for c_mips: packs a byte stream into 32-bit words, writes them
// into instruction memory and holds the core in reset until loading has settled.
module c_ins_loader #(
  parameter int DEPTH      = 64,
  parameter int BIG_ENDIAN = 1,
  parameter int RST_HOLD   = 4
) (
  input  logic           i_c_sys_clock,
  input  logic           i_c_sys_reset_n,
  c_ins_loader_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(RST_HOLD) + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PAD, S_HOLD, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   word_q, word_d;
  logic [31:0]   write_ins_q, write_ins_d;
  logic          ins_wr_q, ins_wr_d;
  logic [AW-1:0] ins_addr_q, ins_addr_d;
  logic [CW-1:0] word_count_q, word_count_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  logic [CW-1:0] committed;
  logic          full;
  logic          byte_ready;
  logic          xfer;
  logic [1:0]    lane;
  logic [31:0]   merged;

  // A word whose strobe is in flight already counts, so the stream stalls right after the last word.
  always_comb begin
    committed  = word_count_q + CW'(ins_wr_q);
    full       = committed >= CW'(DEPTH);
    byte_ready = (state_q == S_LOAD) && !full;
    xfer       = byte_ready && bus.i_c_byte_valid;
    lane       = (BIG_ENDIAN != 0) ? ~idx_q : idx_q;
    merged     = (idx_q == 2'd0) ? 32'd0 : word_q;
    merged[{lane, 3'b000} +: 8] = bus.i_c_byte;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    word_d       = word_q;
    write_ins_d  = write_ins_q;
    ins_wr_d     = 1'b0;
    ins_addr_d   = ins_addr_q;
    word_count_d = word_count_q;
    hold_cnt_d   = hold_cnt_q;

    // Address and count advance on the cycle after each strobe; address parks at the top word.
    if (ins_wr_q) begin
      word_count_d = word_count_q + CW'(1);
      if (ins_addr_q != AW'(DEPTH - 1)) begin
        ins_addr_d = ins_addr_q + AW'(1);
      end
    end

    case (state_q)
      S_IDLE, S_RUN: begin
        if (bus.i_c_load_start) begin
          state_d      = S_LOAD;
          idx_d        = 2'd0;
          ins_addr_d   = '0;
          word_count_d = '0;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          word_d = merged;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            write_ins_d = merged;
            ins_wr_d    = 1'b1;
          end
        end
        if (full) begin
          state_d    = S_HOLD;
          hold_cnt_d = '0;
        end else if (bus.i_c_load_end) begin
          hold_cnt_d = '0;
          state_d    = (idx_d != 2'd0) ? S_PAD : S_HOLD;
        end
      end
      S_PAD: begin
        write_ins_d = word_q;
        ins_wr_d    = 1'b1;
        idx_d       = 2'd0;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        // Counting only starts once no strobe is pending.
        if (!ins_wr_q) begin
          if (hold_cnt_q == HW'(RST_HOLD - 1)) begin
            state_d = S_RUN;
          end else begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_c_sys_clock or negedge i_c_sys_reset_n) begin
    if (!i_c_sys_reset_n) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      word_q       <= 32'd0;
      write_ins_q  <= 32'd0;
      ins_wr_q     <= 1'b0;
      ins_addr_q   <= '0;
      word_count_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      write_ins_q  <= write_ins_d;
      ins_wr_q     <= ins_wr_d;
      ins_addr_q   <= ins_addr_d;
      word_count_q <= word_count_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign bus.o_c_byte_ready = byte_ready;
  assign bus.o_c_write_ins  = write_ins_q;
  assign bus.o_c_ins_wr     = ins_wr_q;
  assign bus.o_c_ins_addr   = ins_addr_q;
  assign bus.o_c_word_count = word_count_q;
  assign bus.o_c_cpu_reset  = (state_q != S_RUN);
  assign bus.o_c_load_done  = (state_q == S_RUN);
endmodule
